mod_port: RTL and testbench

MOD_PORT -- requirements
Module: mod_port

---
 rtl/mod_port.sv | 66 ++++++
 tb/tb_mod_port.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mod_port.sv
// rtl/mod_port.sv - single-clock FIFO with wrap-bit pointers, occupancy flags and overflow/underflow pulses
module mod_port #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [DATA_W-1:0]        wData,
    input  logic                     winc,
    input  logic                     rinc,
    output logic [DATA_W-1:0]        rData,
    output logic                     wFull,
    output logic                     rEmpty,
    output logic                     wAlmostFull,
    output logic                     rAlmostEmpty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT = (AW+1)'(AE_LEVEL);

    logic [AW:0]       wPtr;
    logic [AW:0]       rPtr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              doWrite;
    logic              doRead;

    assign rEmpty       = (wPtr == rPtr);
    assign wFull        = (wPtr[AW-1:0] == rPtr[AW-1:0]) && (wPtr[AW] != rPtr[AW]);
    assign count        = wPtr - rPtr;
    assign wAlmostFull  = (count >= AF_CNT);
    assign rAlmostEmpty = (count <= AE_CNT);

    // A simultaneous read frees the slot the write lands in, so a full FIFO still accepts it.
    assign doRead  = rinc && !rEmpty;
    assign doWrite = winc && (!wFull || rinc);

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            wPtr      <= '0;
            rPtr      <= '0;
            rData     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (doWrite) wPtr <= wPtr + 1'b1;
            if (doRead) begin
                rPtr  <= rPtr + 1'b1;
                rData <= mem[rPtr[AW-1:0]];
            end
            overflow  <= winc && wFull && !rinc;
            underflow <= rinc && rEmpty;
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge wclk) begin
        if (doWrite) mem[wPtr[AW-1:0]] <= wData;
    end

endmodule

// File: tb/tb_mod_port.sv
// tb/tb_mod_port.sv - scoreboard bench for mod_port
module tb_mod_port;

    logic       wclk = 1'b0;
    logic       wrst = 1'b0;
    logic [7:0] wData = '0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] rData;
    logic       wFull, rEmpty, wAlmostFull, rAlmostEmpty, overflow, underflow;
    logic [4:0] count;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb [$];
    logic       expRd, expOvf, expUnf;
    logic [7:0] expData;
    logic [7:0] lastData;

    mod_port dut (
        .wclk(wclk), .wrst(wrst), .wData(wData), .winc(winc), .rinc(rinc),
        .rData(rData), .wFull(wFull), .rEmpty(rEmpty), .wAlmostFull(wAlmostFull),
        .rAlmostEmpty(rAlmostEmpty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 wclk = ~wclk;

    // Drives one edge and updates the scoreboard from the bench's own FIFO model.
    task automatic do_op(input logic w, input logic r, input logic [7:0] d);
        logic full, empty, acceptW;
        full    = (sb.size() == 16);
        empty   = (sb.size() == 0);
        expRd   = r && !empty;
        acceptW = w && (!full || r);
        expOvf  = w && full && !r;
        expUnf  = r && empty;
        if (expRd) begin
            expData  = sb.pop_front();
            lastData = expData;
        end
        if (acceptW) sb.push_back(d);
        winc = w; rinc = r; wData = d;
        @(posedge wclk);
        #1;
        winc = 1'b0; rinc = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (rEmpty !== 1'b1) begin errors++; $display("FAIL reset_rEmpty got=%b exp=1", rEmpty); end
        checks++; if (wFull !== 1'b0) begin errors++; $display("FAIL reset_wFull got=%b exp=0", wFull); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (rData !== 8'h00) begin errors++; $display("FAIL reset_rData got=%h exp=00", rData); end
        checks++; if (rAlmostEmpty !== 1'b1 || wAlmostFull !== 1'b0) begin errors++; $display("FAIL reset_almost got=%b%b exp=10", rAlmostEmpty, wAlmostFull); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", overflow, underflow); end
        @(negedge wclk);
        wrst = 1'b1;
        sb.delete();
        lastData = 8'h00;
    endtask

    task automatic test_basic;
        for (int i = 1; i <= 3; i++) do_op(1'b1, 1'b0, 8'(i));
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count3 got=%0d exp=3", count); end
        for (int i = 1; i <= 3; i++) begin
            do_op(1'b0, 1'b1, 8'h00);
            checks++; if (rData !== expData || expData !== 8'(i)) begin errors++; $display("FAIL basic_read%0d got=%h exp=%h", i, rData, 8'(i)); end
        end
        checks++; if (rEmpty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL basic_empty got=%b/%0d exp=1/0", rEmpty, count); end
    endtask

    task automatic test_full_overflow;
        for (int i = 0; i < 16; i++) begin
            do_op(1'b1, 1'b0, 8'(8'h10 + i));
            checks++; if (count !== 5'(sb.size())) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", count, sb.size()); end
        end
        checks++; if (wFull !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL full_flag got=%b/%0d exp=1/16", wFull, count); end
        checks++; if (wAlmostFull !== 1'b1 || rAlmostEmpty !== 1'b0) begin errors++; $display("FAIL full_almost got=%b%b exp=10", wAlmostFull, rAlmostEmpty); end
        do_op(1'b1, 1'b0, 8'hEE);
        checks++; if (overflow !== expOvf || overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse got=%b exp=1", overflow); end
        checks++; if (count !== 5'd16 || wFull !== 1'b1) begin errors++; $display("FAIL overflow_count got=%0d exp=16", count); end
        do_op(1'b0, 1'b0, 8'h00);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_rw;
        do_op(1'b1, 1'b1, 8'hAA);
        checks++; if (rData !== 8'h10 || rData !== expData) begin errors++; $display("FAIL fullrw_oldest got=%h exp=10", rData); end
        checks++; if (wFull !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL fullrw_full got=%b/%0d exp=1/16", wFull, count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullrw_ovf got=%b exp=0", overflow); end
        for (int i = 1; i <= 16; i++) begin
            do_op(1'b0, 1'b1, 8'h00);
            checks++; if (rData !== expData) begin errors++; $display("FAIL drain_read%0d got=%h exp=%h", i, rData, expData); end
        end
        checks++; if (rData !== 8'hAA) begin errors++; $display("FAIL fullrw_last got=%h exp=aa", rData); end
        checks++; if (rEmpty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL drain_empty got=%b/%0d exp=1/0", rEmpty, count); end
    endtask

    task automatic test_underflow;
        do_op(1'b0, 1'b1, 8'h00);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_pulse got=%b exp=1", underflow); end
        checks++; if (rData !== lastData || rEmpty !== 1'b1) begin errors++; $display("FAIL underflow_hold got=%h/%b exp=%h/1", rData, rEmpty, lastData); end
        do_op(1'b1, 1'b1, 8'h5C);
        checks++; if (underflow !== expUnf || count !== 5'd1 || rData !== lastData) begin errors++; $display("FAIL empty_rw got=%b/%0d/%h exp=1/1/%h", underflow, count, rData, lastData); end
        do_op(1'b0, 1'b0, 8'h00);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got=%b exp=0", underflow); end
        do_op(1'b0, 1'b1, 8'h00);
        checks++; if (rData !== 8'h5C) begin errors++; $display("FAIL empty_rw_data got=%h exp=5c", rData); end
    endtask

    task automatic test_interleave;
        int written = 0;
        logic w, r;
        while (written < 40 || sb.size() > 0) begin
            if (written >= 40) begin w = 1'b0; r = 1'b1; end
            else if (sb.size() < 1) begin w = 1'b1; r = 1'b0; end
            else if (sb.size() >= 10) begin w = 1'b0; r = 1'b1; end
            else begin w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
            if (w) written++;
            do_op(w, r, 8'($urandom));
            if (expRd) begin
                checks++; if (rData !== expData) begin errors++; $display("FAIL stream_read got=%h exp=%h", rData, expData); end
            end
            checks++;
            if (count !== 5'(sb.size()) || rAlmostEmpty !== (sb.size() <= 2) || wAlmostFull !== (sb.size() >= 14)) begin
                errors++; $display("FAIL stream_count got=%0d/%b%b exp=%0d", count, rAlmostEmpty, wAlmostFull, sb.size());
            end
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 8'(8'h30 + i));
        do_op(1'b0, 1'b1, 8'h00);
        #2;
        wrst = 1'b0;
        #1;
        checks++; if (rEmpty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL async_rst got=%b/%0d exp=1/0", rEmpty, count); end
        checks++; if (rData !== 8'h00) begin errors++; $display("FAIL async_rst_rData got=%h exp=00", rData); end
        sb.delete();
        @(negedge wclk);
        wrst = 1'b1;
        do_op(1'b1, 1'b0, 8'h77);
        checks++; if (count !== 5'd1 || rEmpty !== 1'b0) begin errors++; $display("FAIL post_rst_write got=%0d exp=1", count); end
        do_op(1'b0, 1'b1, 8'h00);
        checks++; if (rData !== 8'h77) begin errors++; $display("FAIL post_rst_read got=%h exp=77", rData); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overflow();
        test_full_rw();
        test_underflow();
        test_interleave();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
